// File: rtl/uart_pkg.sv
// Shared UART definitions: frame layout and receive-side state encoding.
// Used by the rx sampler, the deframe stage and the tx framer.
package uart_pkg;

    localparam int FRAME_W    = 11;
    localparam int START_IDX  = 0;
    localparam int DATA_LSB   = 1;
    localparam int DATA_MSB   = 8;
    localparam int PARITY_IDX = 9;
    localparam int STOP_IDX   = 10;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        DONE,
        BREAK_WAIT
    } rx_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// Reset value is a parameter so idle-high and idle-low lines can share it.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_sampler.sv
// UART receive front end: synchronises rx, validates the start bit, samples
// each bit at mid-bit and hands the 11-bit frame downstream with a strobe.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx,
    output logic [FRAME_W-1:0] data_parall,
    output logic               received_flag,
    output logic               frame_err,
    output logic               busy
);

    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int HALF = CLKS_PER_BIT / 2;

    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(HALF - 1);
    localparam logic [3:0]    BIT_LAST = 4'(FRAME_W - 1);

    logic               rx_s;
    rx_state_e          state;
    logic [CW-1:0]      clk_cnt;
    logic [3:0]         bit_cnt;
    logic [FRAME_W-1:0] shreg;

    uart_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            clk_cnt       <= '0;
            bit_cnt       <= '0;
            shreg         <= '0;
            data_parall   <= '0;
            received_flag <= 1'b0;
            frame_err     <= 1'b0;
            busy          <= 1'b0;
        end else begin
            received_flag <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (!rx_s) begin
                        state   <= START;
                        clk_cnt <= '0;
                        busy    <= 1'b1;
                    end
                end
                START: begin
                    if (clk_cnt == CNT_MID) begin
                        clk_cnt <= '0;
                        if (!rx_s) begin
                            shreg   <= {1'b0, shreg[FRAME_W-1:1]};
                            bit_cnt <= 4'd1;
                            state   <= DATA;
                        end else begin
                            // too short to be a start bit: drop it silently
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (clk_cnt == CNT_LAST) begin
                        clk_cnt <= '0;
                        shreg   <= {rx_s, shreg[FRAME_W-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == BIT_LAST)
                            state <= DONE;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                DONE: begin
                    data_parall   <= shreg;
                    received_flag <= 1'b1;
                    frame_err     <= ~shreg[STOP_IDX];
                    busy          <= 1'b0;
                    bit_cnt       <= '0;
                    // a low stop bit may be a break; wait for the line to recover
                    state         <= shreg[STOP_IDX] ? IDLE : BREAK_WAIT;
                end
                BREAK_WAIT: begin
                    busy <= 1'b0;
                    if (rx_s)
                        state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed bench for uart_rx_sampler at CLKS_PER_BIT=16 (bit period 160 time units).
// A monitor records every strobe; the main sequence checks against hand-computed frames.
module tb_uart_rx_sampler;

    localparam int CPB = 16;
    localparam int BP  = CPB * 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx  = 1'b1;
    logic [10:0] data_parall;
    logic        received_flag;
    logic        frame_err;
    logic        busy;

    int checks = 0;
    int errs   = 0;
    int cyc    = 0;
    int t_fall = 0;
    int dbl    = 0;
    logic        prev_flag = 1'b0;
    logic [10:0] q_data[$];
    int          q_cyc[$];
    logic        q_ferr[$];

    uart_rx_sampler #(.CLKS_PER_BIT(CPB)) dut (
        .clk           (clk),
        .rst           (rst),
        .rx            (rx),
        .data_parall   (data_parall),
        .received_flag (received_flag),
        .frame_err     (frame_err),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (received_flag) begin
            if (prev_flag) dbl = dbl + 1;
            q_data.push_back(data_parall);
            q_cyc.push_back(cyc);
            q_ferr.push_back(frame_err);
        end
        prev_flag = received_flag;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp, input int bp);
        logic [10:0] f;
        f = {stp, par, d, 1'b0};
        t_fall = cyc;
        for (int i = 0; i < 11; i++) begin
            rx = f[i];
            #(bp);
        end
    endtask

    initial begin
        int n0;
        int lat;
        logic [7:0] rb;
        logic       rp;

        repeat (3) @(negedge clk);
        chk("rst_data",  32'(data_parall),   32'h000);
        chk("rst_flag",  32'(received_flag), 32'h0);
        chk("rst_ferr",  32'(frame_err),     32'h0);
        chk("rst_busy",  32'(busy),          32'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // 0xA5, parity 0, stop 1
        n0 = q_data.size();
        fork
            send_frame(8'hA5, 1'b0, 1'b1, BP);
            begin
                repeat (50) @(negedge clk);
                chk("a5_busy_mid", 32'(busy), 32'h1);
            end
        join
        @(negedge clk);
        chk("a5_count", 32'(q_data.size() - n0), 32'd1);
        if (q_data.size() > n0) begin
            chk("a5_data", 32'(q_data[n0]), 32'h54A);
            chk("a5_ferr", 32'(q_ferr[n0]), 32'h0);
            lat = q_cyc[n0] - t_fall;
            chk("a5_latency", 32'(lat >= 170 && lat <= 174), 32'h1);
        end
        chk("a5_busy_after", 32'(busy), 32'h0);
        chk("a5_hold", 32'(data_parall), 32'h54A);

        // 4-cycle glitch is rejected
        n0 = q_data.size();
        @(negedge clk);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        chk("gl_busy_mid", 32'(busy), 32'h1);
        repeat (10) @(negedge clk);
        chk("gl_busy_end", 32'(busy), 32'h0);
        repeat (40) @(negedge clk);
        chk("gl_count", 32'(q_data.size() - n0), 32'd0);
        chk("gl_data", 32'(data_parall), 32'h54A);

        // 0x3C with stop 0, then break held low
        n0 = q_data.size();
        @(negedge clk);
        send_frame(8'h3C, 1'b0, 1'b0, BP);
        #(40 * BP);
        chk("brk_count", 32'(q_data.size() - n0), 32'd1);
        chk("brk_data", 32'(data_parall), 32'h078);
        chk("brk_ferr", 32'(frame_err), 32'h1);
        chk("brk_busy", 32'(busy), 32'h0);
        rx = 1'b1;
        #(2 * BP);
        chk("brk_nostrobe", 32'(q_data.size() - n0), 32'd1);
        chk("brk_ferr_held", 32'(frame_err), 32'h1);
        @(negedge clk);
        send_frame(8'h3C, 1'b0, 1'b1, BP);
        #(BP);
        chk("brk_fresh_count", 32'(q_data.size() - n0), 32'd2);
        chk("brk_fresh_data", 32'(data_parall), 32'h478);
        chk("brk_fresh_ferr", 32'(frame_err), 32'h0);

        // back-to-back 0x00 then 0xFF, no idle gap
        n0 = q_data.size();
        @(negedge clk);
        send_frame(8'h00, 1'b0, 1'b1, BP);
        send_frame(8'hFF, 1'b0, 1'b1, BP);
        rx = 1'b1;
        #(BP);
        chk("b2b_count", 32'(q_data.size() - n0), 32'd2);
        if (q_data.size() >= n0 + 2) begin
            chk("b2b_data0", 32'(q_data[n0]),     32'h400);
            chk("b2b_data1", 32'(q_data[n0 + 1]), 32'h5FE);
            lat = q_cyc[n0 + 1] - q_cyc[n0];
            chk("b2b_spacing", 32'(lat >= 175 && lat <= 177), 32'h1);
        end

        // reset during data bit 4 of 0x81, held until the line is idle again
        n0 = q_data.size();
        @(negedge clk);
        fork
            send_frame(8'h81, 1'b0, 1'b1, BP);
            begin
                #(5 * BP + 80);
                @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                chk("rr_data", 32'(data_parall),   32'h000);
                chk("rr_flag", 32'(received_flag), 32'h0);
                chk("rr_ferr", 32'(frame_err),     32'h0);
                chk("rr_busy", 32'(busy),          32'h0);
            end
        join
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("rr_nostrobe", 32'(q_data.size() - n0), 32'd0);
        send_frame(8'h81, 1'b0, 1'b1, BP);
        #(BP);
        chk("rr_count", 32'(q_data.size() - n0), 32'd1);
        chk("rr_data2", 32'(data_parall), 32'h502);

        // random bytes and parity with +/-2% baud skew
        for (int k = 0; k < 8; k++) begin
            rb = 8'($urandom_range(0, 255));
            rp = 1'($urandom_range(0, 1));
            n0 = q_data.size();
            @(negedge clk);
            send_frame(rb, rp, 1'b1, (k % 2 == 0) ? BP - 3 : BP + 3);
            rx = 1'b1;
            #(BP);
            chk("skew_count", 32'(q_data.size() - n0), 32'd1);
            chk("skew_data", 32'(data_parall), 32'({1'b1, rp, rb, 1'b0}));
            chk("skew_ferr", 32'(frame_err), 32'h0);
        end

        chk("no_double_strobe", 32'(dbl), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errs);
        $finish;
    end

endmodule
